// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
// The optional auto-repeat feature is enabled by defining KEYPAD_REPEAT_EN.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } kp_state_t;

  typedef logic [3:0] key_code_t;

  localparam logic [3:0] COL_RESET = 4'b1110;

  // Returns {key_present, row_idx}; the lowest-index low row wins.
  function automatic logic [2:0] row_decode(input logic [3:0] rows);
    row_decode = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if (!rows[i]) row_decode = {1'b1, 2'(i)};
    end
  endfunction

  function automatic logic [1:0] col_index(input logic [3:0] col);
    case (col)
      4'b1110: col_index = 2'd0;
      4'b1101: col_index = 2'd1;
      4'b1011: col_index = 2'd2;
      4'b0111: col_index = 2'd3;
      default: col_index = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running prescaler producing a one-cycle tick every 2**SCAN_DIV_W clocks.
// Part of keypad_scanner_4x4 (optional feature macro: KEYPAD_REPEAT_EN, unused here).
module scan_tick_gen #(
  parameter int SCAN_DIV_W = 17
) (
  input  logic i_clk,
  input  logic i_reset,
  output logic o_tick
);

  logic [SCAN_DIV_W-1:0] prescaler_q;
  logic [SCAN_DIV_W-1:0] prescaler_d;

  always_comb begin
    prescaler_d = prescaler_q + SCAN_DIV_W'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) prescaler_q <= '0;
    else         prescaler_q <= prescaler_d;
  end

  assign o_tick = &prescaler_q;

endmodule

// File: rtl/keypad_scanner_4x4.sv
// 4x4 active-low keypad scanner with tick-based press/release debounce.
// Define KEYPAD_REPEAT_EN to re-strobe o_key_valid while a key stays held.
module keypad_scanner_4x4
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV_W     = 17,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_DELAY   = 50,
  parameter int REPEAT_PERIOD  = 10
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [3:0] i_row,
  output logic [3:0] o_col,
  output logic [3:0] o_key_code,
  output logic       o_key_valid,
  output logic       o_key_pressed
);

  // Period normally sits below the delay, so it rarely widens the counters.
  localparam int CNT_MAX0 = (DEBOUNCE_SCANS > REPEAT_DELAY) ? DEBOUNCE_SCANS : REPEAT_DELAY;
  localparam int CNT_MAX  = (CNT_MAX0 > REPEAT_PERIOD) ? CNT_MAX0 : REPEAT_PERIOD;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t CNT_SAT = cnt_t'(CNT_MAX);
  localparam cnt_t DS_M1   = cnt_t'(DEBOUNCE_SCANS - 1);

  function automatic cnt_t sat_inc(input cnt_t v);
    return (v == CNT_SAT) ? v : v + cnt_t'(1);
  endfunction

  logic       tick;
  logic [3:0] row_meta_q, rows_s_q;
  logic [3:0] col_q, col_d;
  kp_state_t  state_q, state_d;
  key_code_t  cand_q, cand_d;
  key_code_t  key_code_q, key_code_d;
  cnt_t       dcnt_q, dcnt_d;
  cnt_t       rcnt_q, rcnt_d;
  logic       key_valid_q, key_valid_d;
  logic       key_pressed_q, key_pressed_d;
  logic [2:0] row_hit;
  key_code_t  code_now;
  logic [3:0] col_next;

`ifdef KEYPAD_REPEAT_EN
  localparam cnt_t RD_M1 = cnt_t'(REPEAT_DELAY - 1);
  localparam cnt_t RP_M1 = cnt_t'(REPEAT_PERIOD - 1);
  cnt_t rpt_cnt_q, rpt_cnt_d;
  logic rep_done_q, rep_done_d;
`endif

  scan_tick_gen #(.SCAN_DIV_W(SCAN_DIV_W)) u_tick (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .o_tick  (tick)
  );

  assign row_hit  = row_decode(rows_s_q);
  assign code_now = {col_index(col_q), row_hit[1:0]};
  assign col_next = {col_q[2:0], col_q[3]};

  always_comb begin
    col_d         = col_q;
    state_d       = state_q;
    cand_d        = cand_q;
    key_code_d    = key_code_q;
    dcnt_d        = dcnt_q;
    rcnt_d        = rcnt_q;
    key_valid_d   = 1'b0;
    key_pressed_d = key_pressed_q;
`ifdef KEYPAD_REPEAT_EN
    rpt_cnt_d     = rpt_cnt_q;
    rep_done_d    = rep_done_q;
`endif
    if (tick) begin
      case (state_q)
        SCAN: begin
          if (row_hit[2]) begin
            cand_d  = code_now;
            dcnt_d  = cnt_t'(1);
            state_d = DEBOUNCE;
          end else begin
            col_d = col_next;
          end
        end
        DEBOUNCE: begin
          if (row_hit[2] && (code_now == cand_q)) begin
            dcnt_d = sat_inc(dcnt_q);
            if (dcnt_q >= DS_M1) begin
              key_code_d    = cand_q;
              key_valid_d   = 1'b1;
              key_pressed_d = 1'b1;
              rcnt_d        = '0;
              state_d       = HELD;
`ifdef KEYPAD_REPEAT_EN
              rpt_cnt_d     = '0;
              rep_done_d    = 1'b0;
`endif
            end
          end else begin
            dcnt_d  = '0;
            col_d   = col_next;
            state_d = SCAN;
          end
        end
        HELD: begin
          if (row_hit[2]) begin
            rcnt_d = '0;
`ifdef KEYPAD_REPEAT_EN
            // First repeat waits the long delay, later ones the short period.
            if ((!rep_done_q && rpt_cnt_q >= RD_M1) || (rep_done_q && rpt_cnt_q >= RP_M1)) begin
              key_valid_d = 1'b1;
              rpt_cnt_d   = '0;
              rep_done_d  = 1'b1;
            end else begin
              rpt_cnt_d = sat_inc(rpt_cnt_q);
            end
`endif
          end else begin
`ifdef KEYPAD_REPEAT_EN
            rpt_cnt_d  = '0;
            rep_done_d = 1'b0;
`endif
            if (rcnt_q >= DS_M1) begin
              rcnt_d        = '0;
              key_pressed_d = 1'b0;
              col_d         = col_next;
              state_d       = SCAN;
            end else begin
              rcnt_d = sat_inc(rcnt_q);
            end
          end
        end
        default: begin
          state_d = SCAN;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      row_meta_q    <= 4'hF;
      rows_s_q      <= 4'hF;
      col_q         <= COL_RESET;
      state_q       <= SCAN;
      cand_q        <= '0;
      key_code_q    <= '0;
      dcnt_q        <= '0;
      rcnt_q        <= '0;
      key_valid_q   <= 1'b0;
      key_pressed_q <= 1'b0;
    end else begin
      row_meta_q    <= i_row;
      rows_s_q      <= row_meta_q;
      col_q         <= col_d;
      state_q       <= state_d;
      cand_q        <= cand_d;
      key_code_q    <= key_code_d;
      dcnt_q        <= dcnt_d;
      rcnt_q        <= rcnt_d;
      key_valid_q   <= key_valid_d;
      key_pressed_q <= key_pressed_d;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rpt_cnt_q  <= '0;
      rep_done_q <= 1'b0;
    end else begin
      rpt_cnt_q  <= rpt_cnt_d;
      rep_done_q <= rep_done_d;
    end
  end
`endif

  assign o_col         = col_q;
  assign o_key_code    = key_code_q;
  assign o_key_valid   = key_valid_q;
  assign o_key_pressed = key_pressed_q;

endmodule
